reg_bus_master: RTL and testbench
=================================

REG_BUS_MASTER -- requirements
Module: reg_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd1000, meaning max cycles waiting on rsp_ready before abort.
REQ-002 SHALL have ports: clk in 1, sole clock; reset_i in 1, synchronous active-high reset.
REQ-003 SHALL have ports: cmd_data in 8, command byte stream; cmd_valid in 1; cmd_ready out 1.
REQ-004 SHALL have ports: rsp_data out 8, read-data byte stream; rsp_valid out 1; rsp_ready in 1.
REQ-005 SHALL have ports: reg_address out 6; reg_bytecnt out 16; reg_datao out 8, write data to slaves; reg_datai in 8, read data from slaves; reg_size out 16.
REQ-006 SHALL have ports: reg_read out 1; reg_write out 1; reg_addrvalid out 1; reg_hypaddress out 6; reg_hyplen in 16.
REQ-007 SHALL have ports: busy out 1, transaction in progress; err out 1, sticky error flag.

Function
REQ-008 Command framing: byte0 = {rw[7] (1=read), rsvd[6], addr[5:0]}; byte1 = len; writes then carry len data bytes.
REQ-009 len=0 SHALL mean "use reg_hyplen": reg_hypaddress driven with addr one cycle, reg_hyplen sampled next cycle, clamped to 255.
REQ-010 Effective length 0 (len=0 and hyplen=0) SHALL complete with no bus strobes, set err, return to IDLE.
REQ-011 States: IDLE -> GET_LEN -> [HYP] -> WR_DATA/WR_STROBE (write) or RD_STROBE -> RD_CAP -> RD_SEND (read) -> DONE -> IDLE.
REQ-012 Byte handshake on cmd and rsp SHALL occur only when valid&ready high on the same clk edge.
REQ-013 cmd_ready SHALL be high only in IDLE, GET_LEN, WR_DATA.
REQ-014 reg_address and reg_size (effective length) SHALL be stable and reg_addrvalid high from HYP/first strobe through DONE.
REQ-015 Write: each accepted data byte SHALL produce exactly one single-cycle reg_write pulse, next cycle, with reg_datao = byte and reg_bytecnt = byte index (0-based).
REQ-016 Read: reg_read single-cycle pulse with reg_bytecnt = index; reg_datai captured on the following cycle (slave read latency 1); byte held on rsp_data with rsp_valid until accepted.
REQ-017 reg_read and reg_write SHALL never be high together and never high outside a transaction.
REQ-018 Next reg_read SHALL NOT issue until previous rsp byte is accepted (at most one byte buffered).
REQ-019 reg_bytecnt SHALL increment by 1 per byte and never exceed reg_size-1; no wrap.
REQ-020 If rsp_valid is stalled TIMEOUT cycles, SHALL drop rsp_valid, set err, abort to DONE.
REQ-021 DONE SHALL last one cycle with reg_addrvalid low; busy high from byte0 acceptance through DONE.
REQ-022 err SHALL clear only on reset_i or on acceptance of a new byte0.
REQ-023 rsvd bit set SHALL be ignored (no error).

Reset
REQ-024 reset_i SHALL be sampled on posedge clk, effective any state including mid-transaction, returning to IDLE next cycle.
REQ-025 Reset values: cmd_ready 0 during reset then 1; rsp_valid, reg_read, reg_write, reg_addrvalid, busy, err 0; reg_address, reg_hypaddress, reg_bytecnt, reg_size, reg_datao, rsp_data 0.
REQ-026 Reset mid-read SHALL discard any buffered rsp byte.

Structure
REQ-027 State encoding, command bit positions, and RD_LATENCY=1 SHALL live in shared include reg_bus_defs.
REQ-028 SHALL be a single module; optional sub-module reg_bus_rsp_buf (one-entry skid buffer) permitted.

Verification
REQ-029 Write: cmd 0x3D,0x04,0x11,0x22,0x33,0x44 -> four reg_write pulses, addr 61, bytecnt 0..3, datao 11,22,33,44, reg_size 4.
REQ-030 Read with hyplen: cmd 0xBC,0x00, slave hyplen 4 -> reg_hypaddress 60, four reads, rsp bytes match slave regs LSB-first, reg_size 4.
REQ-031 Backpressure: read len 3, rsp_ready low 10 cycles per byte -> no extra reg_read, bytes in order, err 0.
REQ-032 Timeout: TIMEOUT=8, read len 2, rsp_ready held low -> rsp_valid drops after 8 cycles, err 1, back to IDLE.
REQ-033 Zero length: cmd 0xBF,0x00, hyplen 0 -> no strobes, err 1, next byte0 clears err.
REQ-034 Reset after second reg_write of 4-byte write -> all strobes low, IDLE next cycle, following command executes normally.

Source files
------------

// File: rtl/reg_bus_master_pkg.sv
// ============================================================================
// Module      : reg_bus_master_pkg
// Description : Shared definitions for the byte-stream register bus master:
//               FSM encoding, command byte layout, slave read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_bus_master_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_GET_LEN   = 4'd1,
        ST_HYP       = 4'd2,
        ST_WR_DATA   = 4'd3,
        ST_WR_STROBE = 4'd4,
        ST_RD_STROBE = 4'd5,
        ST_RD_CAP    = 4'd6,
        ST_RD_SEND   = 4'd7,
        ST_DONE      = 4'd8
    } state_t;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_RSVD_BIT = 6;
    localparam int CMD_ADDR_MSB = 5;

    localparam int         RD_LATENCY  = 1;
    localparam logic [1:0] RD_LAT_LAST = 2'(RD_LATENCY - 1);

    localparam logic [15:0] MAX_LEN = 16'd255;

    // Slave-reported lengths are capped so a transfer never exceeds one len byte.
    function automatic logic [15:0] clamp_len(input logic [15:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bus_master.sv
// ============================================================================
// Module      : reg_bus_master
// Description : Converts a framed command byte stream into register read and
//               write strobes, returning read data on a byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bus_master
    import reg_bus_master_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [5:0]  reg_address,
    output logic [15:0] reg_bytecnt,
    output logic [7:0]  reg_datao,
    input  logic [7:0]  reg_datai,
    output logic [15:0] reg_size,
    output logic        reg_read,
    output logic        reg_write,
    output logic        reg_addrvalid,
    output logic [5:0]  reg_hypaddress,
    input  logic [15:0] reg_hyplen,
    output logic        busy,
    output logic        err
);

    state_t      state_q,   state_d;
    logic        rw_q,      rw_d;
    logic [5:0]  addr_q,    addr_d;
    logic [5:0]  hypaddr_q, hypaddr_d;
    logic [15:0] size_q,    size_d;
    logic [15:0] bytecnt_q, bytecnt_d;
    logic [7:0]  datao_q,   datao_d;
    logic [7:0]  rsp_q,     rsp_d;
    logic        err_q,     err_d;
    logic [15:0] to_cnt_q,  to_cnt_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;

    logic [15:0] w_hyp_len;
    logic        w_last;
    logic        unused_rsvd;

    assign w_hyp_len   = clamp_len(reg_hyplen);
    assign w_last      = (bytecnt_q == size_q - 16'd1);
    assign unused_rsvd = cmd_data[CMD_RSVD_BIT];

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            rw_q      <= 1'b0;
            addr_q    <= 6'd0;
            hypaddr_q <= 6'd0;
            size_q    <= 16'd0;
            bytecnt_q <= 16'd0;
            datao_q   <= 8'd0;
            rsp_q     <= 8'd0;
            err_q     <= 1'b0;
            to_cnt_q  <= 16'd0;
            lat_cnt_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            hypaddr_q <= hypaddr_d;
            size_q    <= size_d;
            bytecnt_q <= bytecnt_d;
            datao_q   <= datao_d;
            rsp_q     <= rsp_d;
            err_q     <= err_d;
            to_cnt_q  <= to_cnt_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        hypaddr_d = hypaddr_q;
        size_d    = size_q;
        bytecnt_d = bytecnt_q;
        datao_d   = datao_q;
        rsp_d     = rsp_q;
        err_d     = err_q;
        to_cnt_d  = to_cnt_q;
        lat_cnt_d = lat_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rw_d      = cmd_data[CMD_RW_BIT];
                    addr_d    = cmd_data[CMD_ADDR_MSB:0];
                    bytecnt_d = 16'd0;
                    err_d     = 1'b0;
                    state_d   = ST_GET_LEN;
                end
            end
            ST_GET_LEN: begin
                if (cmd_valid) begin
                    if (cmd_data == 8'd0) begin
                        hypaddr_d = addr_q;
                        state_d   = ST_HYP;
                    end else begin
                        size_d  = {8'd0, cmd_data};
                        state_d = rw_q ? ST_RD_STROBE : ST_WR_DATA;
                    end
                end
            end
            ST_HYP: begin
                size_d = w_hyp_len;
                if (w_hyp_len == 16'd0) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = rw_q ? ST_RD_STROBE : ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (cmd_valid) begin
                    datao_d = cmd_data;
                    state_d = ST_WR_STROBE;
                end
            end
            ST_WR_STROBE: begin
                if (w_last) begin
                    state_d = ST_DONE;
                end else begin
                    bytecnt_d = bytecnt_q + 16'd1;
                    state_d   = ST_WR_DATA;
                end
            end
            ST_RD_STROBE: begin
                lat_cnt_d = 2'd0;
                state_d   = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                if (lat_cnt_q == RD_LAT_LAST) begin
                    rsp_d    = reg_datai;
                    to_cnt_d = 16'd0;
                    state_d  = ST_RD_SEND;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_RD_SEND: begin
                // The next read is held off here, so at most one byte is ever buffered.
                if (rsp_ready) begin
                    if (w_last) begin
                        state_d = ST_DONE;
                    end else begin
                        bytecnt_d = bytecnt_q + 16'd1;
                        state_d   = ST_RD_STROBE;
                    end
                end else if (to_cnt_q == TIMEOUT - 16'd1) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready      = !reset_i && ((state_q == ST_IDLE) || (state_q == ST_GET_LEN) ||
                                         (state_q == ST_WR_DATA));
    assign rsp_valid      = (state_q == ST_RD_SEND);
    assign rsp_data       = rsp_q;
    assign reg_write      = (state_q == ST_WR_STROBE);
    assign reg_read       = (state_q == ST_RD_STROBE);
    assign reg_addrvalid  = (state_q == ST_HYP)       || (state_q == ST_WR_DATA) ||
                            (state_q == ST_WR_STROBE) || (state_q == ST_RD_STROBE) ||
                            (state_q == ST_RD_CAP)    || (state_q == ST_RD_SEND);
    assign reg_address    = addr_q;
    assign reg_hypaddress = hypaddr_q;
    assign reg_size       = size_q;
    assign reg_bytecnt    = bytecnt_q;
    assign reg_datao      = datao_q;
    assign busy           = (state_q != ST_IDLE);
    assign err            = err_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_master.sv
// ============================================================================
// Module      : tb_reg_bus_master
// Description : Directed self-checking bench for reg_bus_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i = 1'b1;
    logic [15:0] reg_hyplen = 16'd0;

    logic [7:0]  cmd_data = 8'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [5:0]  reg_address;
    logic [15:0] reg_bytecnt;
    logic [7:0]  reg_datao;
    logic [7:0]  reg_datai = 8'd0;
    logic [15:0] reg_size;
    logic        reg_read;
    logic        reg_write;
    logic        reg_addrvalid;
    logic [5:0]  reg_hypaddress;
    logic        busy;
    logic        err;

    logic [7:0]  cmd_data_t = 8'd0;
    logic        cmd_valid_t = 1'b0;
    logic        cmd_ready_t;
    logic [7:0]  rsp_data_t;
    logic        rsp_valid_t;
    logic        rsp_ready_t = 1'b0;
    logic [5:0]  reg_address_t;
    logic [15:0] reg_bytecnt_t;
    logic [7:0]  reg_datao_t;
    logic [7:0]  reg_datai_t = 8'd0;
    logic [15:0] reg_size_t;
    logic        reg_read_t;
    logic        reg_write_t;
    logic        reg_addrvalid_t;
    logic [5:0]  reg_hypaddress_t;
    logic        busy_t;
    logic        err_t;

    reg_bus_master dut (
        .clk(clk), .reset_i(reset_i),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datao(reg_datao),
        .reg_datai(reg_datai), .reg_size(reg_size), .reg_read(reg_read),
        .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
        .reg_hypaddress(reg_hypaddress), .reg_hyplen(reg_hyplen),
        .busy(busy), .err(err)
    );

    reg_bus_master #(.TIMEOUT(16'd8)) dut_to (
        .clk(clk), .reset_i(reset_i),
        .cmd_data(cmd_data_t), .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t),
        .rsp_data(rsp_data_t), .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready_t),
        .reg_address(reg_address_t), .reg_bytecnt(reg_bytecnt_t), .reg_datao(reg_datao_t),
        .reg_datai(reg_datai_t), .reg_size(reg_size_t), .reg_read(reg_read_t),
        .reg_write(reg_write_t), .reg_addrvalid(reg_addrvalid_t),
        .reg_hypaddress(reg_hypaddress_t), .reg_hyplen(reg_hyplen),
        .busy(busy_t), .err(err_t)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] slave_mem [0:3];

    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          rd_cnt_t = 0;
    int          both_cnt = 0;
    int          bad_cnt = 0;
    logic [5:0]  wr_ad [0:255];
    logic [15:0] wr_bc [0:255];
    logic [7:0]  wr_do [0:255];
    logic [15:0] wr_sz [0:255];
    logic [15:0] rd_bc [0:255];

    // Slave register file with one cycle of read latency.
    always @(posedge clk) begin
        if (reg_read)   reg_datai   <= slave_mem[reg_bytecnt[1:0]];
        if (reg_read_t) reg_datai_t <= 8'hE0 + reg_bytecnt_t[7:0];
    end

    always @(negedge clk) begin
        if (reg_write) begin
            wr_ad[wr_cnt] <= reg_address;
            wr_bc[wr_cnt] <= reg_bytecnt;
            wr_do[wr_cnt] <= reg_datao;
            wr_sz[wr_cnt] <= reg_size;
            wr_cnt        <= wr_cnt + 1;
        end
        if (reg_read) begin
            rd_bc[rd_cnt] <= reg_bytecnt;
            rd_cnt        <= rd_cnt + 1;
        end
        if (reg_read && reg_write) both_cnt <= both_cnt + 1;
        if ((reg_read || reg_write) && (!busy || !reg_addrvalid)) bad_cnt <= bad_cnt + 1;
        if (reg_read_t) rd_cnt_t <= rd_cnt_t + 1;
    end

    task automatic send_byte(input bit t, input logic [7:0] b);
        int n = 0;
        if (t) begin cmd_data_t = b; cmd_valid_t = 1'b1; end
        else   begin cmd_data   = b; cmd_valid   = 1'b1; end
        while (((t ? cmd_ready_t : cmd_ready) !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL cmd_handshake byte=%h: cmd_ready low for %0d cycles, required accept", b, n);
        end
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_valid_t = 1'b0;
    endtask

    task automatic wait_idle(input bit t);
        int n = 0;
        while (((t ? busy_t : busy) !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL idle_wait: busy still high after %0d cycles, required 0", n);
        end
    endtask

    task automatic recv(input int n_bytes, input int stall, input int base_rd);
        logic [7:0] got;
        int n;
        for (int i = 0; i < n_bytes; i++) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            repeat (stall) @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rd_cnt - base_rd !== i + 1) begin
                errors++;
                $display("FAIL rsp_hold[%0d]: valid=%b reads=%0d, required valid=1 reads=%0d",
                         i, rsp_valid, rd_cnt - base_rd, i + 1);
            end
            rsp_ready = 1'b1;
            got = rsp_data;
            @(negedge clk);
            rsp_ready = 1'b0;
            checks++;
            if (got !== slave_mem[i]) begin
                errors++;
                $display("FAIL rsp_data[%0d]: got %h, required %h", i, got, slave_mem[i]);
            end
        end
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, reg_read, reg_write, reg_addrvalid, busy, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {cmd_ready, rsp_valid, reg_read, reg_write, reg_addrvalid, busy, err});
        end
        checks++;
        if ({reg_address, reg_hypaddress, reg_bytecnt, reg_size, reg_datao, rsp_data} !== 60'd0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0",
                     {reg_address, reg_hypaddress, reg_bytecnt, reg_size, reg_datao, rsp_data});
        end
        reset_i = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || cmd_ready_t !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b/%b, required 1/1", cmd_ready, cmd_ready_t);
        end
    endtask

    task automatic test_write;
        logic [7:0] seq [0:5];
        logic [7:0] exp_d [0:3];
        int base;
        seq = '{8'h3D, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        base = wr_cnt;
        for (int i = 0; i < 6; i++) send_byte(1'b0, seq[i]);
        wait_idle(1'b0);
        checks++;
        if (wr_cnt - base !== 4) begin
            errors++;
            $display("FAIL write_count: got %0d, required 4", wr_cnt - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({wr_ad[base+i], wr_bc[base+i], wr_do[base+i], wr_sz[base+i]} !==
                {6'd61, 16'(i), exp_d[i], 16'd4}) begin
                errors++;
                $display("FAIL write_beat[%0d]: addr=%0d cnt=%0d data=%h size=%0d, required 61 %0d %h 4",
                         i, wr_ad[base+i], wr_bc[base+i], wr_do[base+i], wr_sz[base+i], i, exp_d[i]);
            end
        end
        checks++;
        if (err !== 1'b0 || both_cnt !== 0 || bad_cnt !== 0) begin
            errors++;
            $display("FAIL write_status: err=%b overlap=%0d stray=%0d, required 0 0 0",
                     err, both_cnt, bad_cnt);
        end
    endtask

    task automatic test_read_hyp;
        int base;
        slave_mem = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        reg_hyplen = 16'd4;
        base = rd_cnt;
        send_byte(1'b0, 8'hBC);
        send_byte(1'b0, 8'h00);
        recv(4, 0, base);
        wait_idle(1'b0);
        checks++;
        if ({reg_hypaddress, reg_address, reg_size} !== {6'd60, 6'd60, 16'd4}) begin
            errors++;
            $display("FAIL read_hyp_regs: hyp=%0d addr=%0d size=%0d, required 60 60 4",
                     reg_hypaddress, reg_address, reg_size);
        end
        checks++;
        if (rd_cnt - base !== 4 || err !== 1'b0) begin
            errors++;
            $display("FAIL read_hyp_count: reads=%0d err=%b, required 4 0", rd_cnt - base, err);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_bc[base+i] !== 16'(i)) begin
                errors++;
                $display("FAIL read_bytecnt[%0d]: got %0d, required %0d", i, rd_bc[base+i], i);
            end
        end
    endtask

    task automatic test_backpressure;
        int base;
        slave_mem = '{8'h5A, 8'h6B, 8'h7C, 8'h00};
        base = rd_cnt;
        send_byte(1'b0, 8'h8A);
        send_byte(1'b0, 8'h03);
        recv(3, 10, base);
        wait_idle(1'b0);
        checks++;
        if (rd_cnt - base !== 3 || err !== 1'b0 || reg_size !== 16'd3 || both_cnt !== 0) begin
            errors++;
            $display("FAIL backpressure: reads=%0d err=%b size=%0d overlap=%0d, required 3 0 3 0",
                     rd_cnt - base, err, reg_size, both_cnt);
        end
    endtask

    task automatic test_timeout;
        int n = 0;
        int high = 0;
        int base;
        base = rd_cnt_t;
        rsp_ready_t = 1'b0;
        send_byte(1'b1, 8'h85);
        send_byte(1'b1, 8'h02);
        while (rsp_valid_t !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (rsp_valid_t === 1'b1 && high < 50) begin
            @(negedge clk);
            high++;
        end
        checks++;
        if (high !== 8) begin
            errors++;
            $display("FAIL timeout_len: rsp_valid high %0d cycles, required 8", high);
        end
        checks++;
        if (err_t !== 1'b1 || rsp_valid_t !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err=%b valid=%b, required 1 0", err_t, rsp_valid_t);
        end
        @(negedge clk);
        checks++;
        if (busy_t !== 1'b0 || cmd_ready_t !== 1'b1 || rd_cnt_t - base !== 1) begin
            errors++;
            $display("FAIL timeout_idle: busy=%b ready=%b reads=%0d, required 0 1 1",
                     busy_t, cmd_ready_t, rd_cnt_t - base);
        end
    endtask

    task automatic test_zero_len;
        int wbase;
        int rbase;
        wbase = wr_cnt;
        rbase = rd_cnt;
        reg_hyplen = 16'd0;
        send_byte(1'b0, 8'hBF);
        send_byte(1'b0, 8'h00);
        wait_idle(1'b0);
        checks++;
        if (err !== 1'b1 || wr_cnt !== wbase || rd_cnt !== rbase) begin
            errors++;
            $display("FAIL zero_len: err=%b writes=%0d reads=%0d, required 1 0 0",
                     err, wr_cnt - wbase, rd_cnt - rbase);
        end
        send_byte(1'b0, 8'h7F);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b, required 0", err);
        end
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h5A);
        wait_idle(1'b0);
        checks++;
        if (wr_cnt - wbase !== 1 || {wr_ad[wbase], wr_bc[wbase], wr_do[wbase]} !==
            {6'd63, 16'd0, 8'h5A} || err !== 1'b0) begin
            errors++;
            $display("FAIL rsvd_write: writes=%0d addr=%0d data=%h err=%b, required 1 63 5a 0",
                     wr_cnt - wbase, wr_ad[wbase], wr_do[wbase], err);
        end
    endtask

    task automatic test_reset_mid;
        int base;
        base = wr_cnt;
        send_byte(1'b0, 8'h02);
        send_byte(1'b0, 8'h04);
        send_byte(1'b0, 8'hAA);
        send_byte(1'b0, 8'hBB);
        reset_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({reg_write, reg_read, reg_addrvalid, busy, cmd_ready} !== 5'b0 || wr_cnt - base !== 2) begin
            errors++;
            $display("FAIL reset_mid: strobes/av/busy/ready=%b writes=%0d, required 00000 2",
                     {reg_write, reg_read, reg_addrvalid, busy, cmd_ready}, wr_cnt - base);
        end
        reset_i = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: ready=%b busy=%b, required 1 0", cmd_ready, busy);
        end
        send_byte(1'b0, 8'h02);
        send_byte(1'b0, 8'h02);
        send_byte(1'b0, 8'hC1);
        send_byte(1'b0, 8'hC2);
        wait_idle(1'b0);
        checks++;
        if (wr_cnt - base !== 4 ||
            {wr_bc[base+2], wr_do[base+2], wr_bc[base+3], wr_do[base+3], wr_sz[base+3]} !==
            {16'd0, 8'hC1, 16'd1, 8'hC2, 16'd2}) begin
            errors++;
            $display("FAIL after_reset_write: writes=%0d d0=%h d1=%h cnt1=%0d, required 4 c1 c2 1",
                     wr_cnt - base, wr_do[base+2], wr_do[base+3], wr_bc[base+3]);
        end
    endtask

    initial begin
        slave_mem = '{8'h00, 8'h00, 8'h00, 8'h00};
        @(negedge clk);
        test_reset();
        test_write();
        test_read_hyp();
        test_backpressure();
        test_timeout();
        test_zero_len();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
